// File: rtl/whack_game_controller.sv
// -----------------------------------------------------------------------------
// whack_game_controller
//
// Top-level sequencer for the whack-a-mole datapath. Walks between the idle
// screen, the gap screen, the four mole screens and the game-over screen,
// driving the datapath's 3-bit state code and a one-cycle hit pulse.
// Mole selection comes from an 8-bit LFSR with a no-back-to-back-repeat rule.
//
// Ports:
//   clk            in   system clock
//   Reset          in   synchronous, active-high reset
//   start          in   start button level (already synchronized)
//   key[3:0]       in   mole hit button levels; key[i] hits mole i
//   enable_control in   one-cycle end-of-phase pulse from the datapath
//   state[2:0]     out  state code to the datapath (also the FSM debug view)
//   player_signal  out  one-cycle correct-hit pulse
//   mole_onehot    out  active mole for display, 0 outside mole screens
//   round[7:0]     out  completed mole rounds in the current game
//   miss_count     out  wrong key presses, saturating at 255
//   game_over      out  high while in the game-over screen
//
// Interface timing: enable_control, start and key are sampled on every rising
// clk edge; there is no back-pressure. Every output is registered, so a change
// decided from inputs sampled in cycle N appears in cycle N+1.
// -----------------------------------------------------------------------------
module whack_game_controller #(
    parameter int         NUM_ROUNDS = 20,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [3:0] key,
    input  logic       enable_control,
    output logic [2:0] state,
    output logic       player_signal,
    output logic [3:0] mole_onehot,
    output logic [7:0] round,
    output logic [7:0] miss_count,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_GAP   = 3'b001,
        S_MOLE0 = 3'b010,
        S_MOLE1 = 3'b011,
        S_MOLE2 = 3'b100,
        S_MOLE3 = 3'b101,
        S_OVER  = 3'b110
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] prev_mole_q, prev_mole_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       start_q;
    logic [3:0] key_q;
    logic [7:0] round_q, round_d;
    logic [7:0] miss_q, miss_d;
    logic       hit_done_q, hit_done_d;
    logic       player_signal_q, player_signal_d;
    logic [3:0] mole_onehot_q, mole_onehot_d;
    logic       game_over_q, game_over_d;

    logic       start_rise;
    logic [3:0] key_rise;
    logic [3:0] wrong_rise;
    logic [1:0] cand;
    logic [1:0] next_mole;
    logic [2:0] cur_idx;
    logic [1:0] cur_mole;
    logic [7:0] round_inc;
    logic [7:0] miss_inc;

    always_comb begin
        start_rise = start & ~start_q;
        key_rise   = key & ~key_q;

        // Fibonacci LFSR, taps 8,6,5,4: maximal length, never reaches zero.
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        // Bump the candidate when it would repeat the previous mole.
        cand      = lfsr_q[1:0];
        next_mole = (cand == prev_mole_q) ? cand + 2'd1 : cand;

        // Mole index while in a mole state: codes 010..101 map to 0..3.
        cur_idx    = state_q - 3'd2;
        cur_mole   = cur_idx[1:0];
        wrong_rise = key_rise & ~(4'b0001 << cur_mole);

        round_inc = round_q + 8'd1;
        miss_inc  = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;

        state_d         = state_q;
        prev_mole_d     = prev_mole_q;
        round_d         = round_q;
        miss_d          = miss_q;
        hit_done_d      = hit_done_q;
        player_signal_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_GAP;
                    round_d = 8'd0;
                    miss_d  = 8'd0;
                end
            end
            S_GAP: begin
                if (|key_rise) miss_d = miss_inc;
                if (enable_control) begin
                    state_d     = state_t'(3'd2 + {1'b0, next_mole});
                    prev_mole_d = next_mole;
                    hit_done_d  = 1'b0;
                end
            end
            S_MOLE0, S_MOLE1, S_MOLE2, S_MOLE3: begin
                // Hit and miss are judged against the current mole even when
                // enable_control ends the phase in the same cycle.
                if (key_rise[cur_mole] && !hit_done_q) begin
                    player_signal_d = 1'b1;
                    hit_done_d      = 1'b1;
                end
                if (|wrong_rise) miss_d = miss_inc;
                if (enable_control) begin
                    round_d = round_inc;
                    state_d = (round_inc == 8'(NUM_ROUNDS)) ? S_OVER : S_GAP;
                end
            end
            S_OVER: begin
                if (start_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;  // code 111 recovers to idle
        endcase

        // Display and game_over follow the next state so they move with it.
        case (state_d)
            S_MOLE0: mole_onehot_d = 4'b0001;
            S_MOLE1: mole_onehot_d = 4'b0010;
            S_MOLE2: mole_onehot_d = 4'b0100;
            S_MOLE3: mole_onehot_d = 4'b1000;
            default: mole_onehot_d = 4'b0000;
        endcase
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q         <= S_IDLE;
            prev_mole_q     <= 2'd0;
            lfsr_q          <= LFSR_SEED;
            // Buttons held through reset release must not look like presses.
            start_q         <= 1'b1;
            key_q           <= 4'hF;
            round_q         <= 8'd0;
            miss_q          <= 8'd0;
            hit_done_q      <= 1'b0;
            player_signal_q <= 1'b0;
            mole_onehot_q   <= 4'd0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_mole_q     <= prev_mole_d;
            lfsr_q          <= lfsr_d;
            start_q         <= start;
            key_q           <= key;
            round_q         <= round_d;
            miss_q          <= miss_d;
            hit_done_q      <= hit_done_d;
            player_signal_q <= player_signal_d;
            mole_onehot_q   <= mole_onehot_d;
            game_over_q     <= game_over_d;
        end
    end

    assign state         = state_q;
    assign player_signal = player_signal_q;
    assign mole_onehot   = mole_onehot_q;
    assign round         = round_q;
    assign miss_count    = miss_q;
    assign game_over     = game_over_q;

endmodule
